// File: rtl/instmem_loader_if.sv
// Host-link byte stream and ROM write port used by instmem_loader.
// master: the loader side (consumes bytes, drives write requests).
// slave:  the environment side (byte source plus ROM write port).
interface instmem_loader_if #(
    parameter int ADDR_BITS = 11,
    parameter int MEM_WIDTH = 16
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 wr_en;
    logic                 wr_ready;
    logic                 wr_isr;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [MEM_WIDTH-1:0] wr_data;

    modport master (
        input  rx_data, rx_valid, wr_ready,
        output rx_ready, wr_en, wr_isr, wr_addr, wr_data
    );

    modport slave (
        output rx_data, rx_valid, wr_ready,
        input  rx_ready, wr_en, wr_isr, wr_addr, wr_data
    );
endinterface

// File: rtl/instmem_loader.sv
// instmem_loader: byte-stream loader for the main and ISR instruction ROMs.
// Frame: TARGET, LEN_LO, LEN_HI, then 2*N data bytes (low byte first).
// The core is held in stall while a frame is loading.
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined, a trailing CHK
// byte (XOR of all data bytes) is required; a mismatch flags err, no done.
module instmem_loader #(
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_BITS = 11,
    parameter int MEM_WIDTH = 16
) (
    input  logic               clk,
    input  logic               nrst,
    instmem_loader_if.master   bus,
    output logic               core_hold,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_FINISH
    } state_t;

    // State entered once the payload (or an empty payload) has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    localparam state_t S_AFTER_DATA = S_FINISH;
`endif

    localparam logic [16:0]          DEPTH_W = 17'(MEM_DEPTH);
    localparam logic [ADDR_BITS:0]   REM_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    state_t                 state_reg, state_next;
    logic                   rx_ready_reg, rx_ready_next;
    logic                   wr_en_reg, wr_en_next;
    logic                   wr_isr_reg, wr_isr_next;
    logic [ADDR_BITS-1:0]   wr_addr_reg, wr_addr_next;
    logic [MEM_WIDTH-1:0]   wr_data_reg, wr_data_next;
    logic                   core_hold_reg, core_hold_next;
    logic                   done_reg, done_next;
    logic                   err_reg, err_next;
    logic                   target_reg, target_next;
    logic [7:0]             len_lo_reg, len_lo_next;
    logic [7:0]             lo_byte_reg, lo_byte_next;
    logic [ADDR_BITS-1:0]   addr_cnt_reg, addr_cnt_next;
    logic [ADDR_BITS:0]     remain_reg, remain_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             chk_reg, chk_next;
`endif

    logic        accept;
    logic        wr_done;
    logic        wr_free;
    logic [15:0] len_word;

    assign accept   = bus.rx_valid && rx_ready_reg;
    assign wr_done  = wr_en_reg && bus.wr_ready;
    // No write outstanding after this cycle.
    assign wr_free  = !wr_en_reg || bus.wr_ready;
    assign len_word = {bus.rx_data, len_lo_reg};

    // Next-state and registered-output logic for the frame parser.
    always_comb begin
        state_next     = state_reg;
        wr_en_next     = wr_en_reg;
        wr_isr_next    = wr_isr_reg;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        core_hold_next = core_hold_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        target_next    = target_reg;
        len_lo_next    = len_lo_reg;
        lo_byte_next   = lo_byte_reg;
        addr_cnt_next  = addr_cnt_reg;
        remain_next    = remain_reg;
`ifdef LOADER_CHECKSUM_EN
        chk_next       = chk_reg;
`endif

        // The write request drops once the ROM port takes it.
        if (wr_done) begin
            wr_en_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (bus.rx_data <= 8'd1) begin
                        target_next    = bus.rx_data[0];
                        // Leave wr_isr alone while a previous write is still pending.
                        if (wr_free) begin
                            wr_isr_next = bus.rx_data[0];
                        end
                        err_next       = 1'b0;
                        core_hold_next = 1'b1;
                        state_next     = S_LEN_LO;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    len_lo_next = bus.rx_data;
                    state_next  = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_next = 8'd0;
`endif
                    if ({1'b0, len_word} > DEPTH_W) begin
                        err_next       = 1'b1;
                        core_hold_next = 1'b0;
                        state_next     = S_IDLE;
                    end else if (len_word == 16'd0) begin
                        state_next = S_AFTER_DATA;
                    end else begin
                        addr_cnt_next = '0;
                        remain_next   = len_word[ADDR_BITS:0];
                        state_next    = S_DATA_LO;
                    end
                end
            end

            S_DATA_LO: begin
                if (accept) begin
                    lo_byte_next = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                    chk_next     = chk_reg ^ bus.rx_data;
`endif
                    state_next   = S_DATA_HI;
                end
            end

            S_DATA_HI: begin
                // rx_ready is only high here when no write is outstanding.
                if (accept) begin
                    wr_en_next    = 1'b1;
                    wr_isr_next   = target_reg;
                    wr_addr_next  = addr_cnt_reg;
                    wr_data_next  = MEM_WIDTH'({bus.rx_data, lo_byte_reg});
                    addr_cnt_next = addr_cnt_reg + ADDR_ONE;
                    remain_next   = remain_reg - REM_ONE;
`ifdef LOADER_CHECKSUM_EN
                    chk_next      = chk_reg ^ bus.rx_data;
`endif
                    state_next    = (remain_reg == REM_ONE) ? S_AFTER_DATA : S_DATA_LO;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (bus.rx_data != chk_reg) begin
                        err_next       = 1'b1;
                        core_hold_next = 1'b0;
                        state_next     = S_IDLE;
                    end else if (wr_free) begin
                        done_next      = 1'b1;
                        core_hold_next = 1'b0;
                        state_next     = S_IDLE;
                    end else begin
                        state_next = S_FINISH;
                    end
                end
            end
`endif

            S_FINISH: begin
                if (wr_free) begin
                    done_next      = 1'b1;
                    core_hold_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Stall the byte stream only while a complete halfword would have to wait.
        rx_ready_next = (state_next != S_FINISH) &&
                        !((state_next == S_DATA_HI) && wr_en_next);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= S_IDLE;
            rx_ready_reg  <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_isr_reg    <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            core_hold_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            target_reg    <= 1'b0;
            len_lo_reg    <= '0;
            lo_byte_reg   <= '0;
            addr_cnt_reg  <= '0;
            remain_reg    <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            rx_ready_reg  <= rx_ready_next;
            wr_en_reg     <= wr_en_next;
            wr_isr_reg    <= wr_isr_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            core_hold_reg <= core_hold_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            target_reg    <= target_next;
            len_lo_reg    <= len_lo_next;
            lo_byte_reg   <= lo_byte_next;
            addr_cnt_reg  <= addr_cnt_next;
            remain_reg    <= remain_next;
`ifdef LOADER_CHECKSUM_EN
            chk_reg       <= chk_next;
`endif
        end
    end

    assign bus.rx_ready = rx_ready_reg;
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_isr   = wr_isr_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;
    assign core_hold    = core_hold_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: doc/instmem_loader.md
# instmem_loader

Byte-stream program loader that fills the halfword-addressed instruction ROMs: main program and ISR. It receives framed bytes from a host-side link (UART receiver or debug bridge), assembles little-endian 16-bit halfwords, and issues sequential write requests into the selected memory. While a load is in progress it holds the core in stall.

## Interface
Parameters:
- `MEM_DEPTH`, 2048, halfword entries per ROM (4 kB each)
- `ADDR_BITS`, 11, halfword address width (log2 MEM_DEPTH)
- `MEM_WIDTH`, 16, memory entry width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  rx_data valid
- `rx_ready`  out  1  loader accepts byte; transfer when rx_valid && rx_ready
- `wr_en`  out  1  write request to ROM
- `wr_ready`  in  1  ROM port accepts write; write completes when wr_en && wr_ready
- `wr_isr`  out  1  0 = main instmem, 1 = isr_mem
- `wr_addr`  out  ADDR_BITS  halfword address
- `wr_data`  out  MEM_WIDTH  halfword {hi byte, lo byte}
- `core_hold`  out  1  stall/hold core while loading
- `done`  out  1  one-cycle pulse, frame loaded successfully
- `err`  out  1  sticky frame error, cleared on next accepted target byte

## Operation
- Frame format: TARGET byte (0x00 main, 0x01 ISR), LEN_LO, LEN_HI (halfword count N, little-endian), then 2N data bytes with the low byte first. With checksum enabled, one CHK byte follows.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, FINISH.
- IDLE, byte accepted:
  - 0x00 or 0x01: latch wr_isr, clear err, set core_hold, go to LEN_LO.
  - Any other value: set err, stay in IDLE.
- LEN_HI: form N.
  - N > MEM_DEPTH: set err, clear core_hold, go to IDLE.
  - N == 0: go to CHK if checksum is enabled, else FINISH.
  - Otherwise: go to DATA_LO. Address counter = 0, remaining = N.
- DATA_LO: latch low byte.
- DATA_HI: latch high byte and raise wr_en with wr_data = {hi, lo} at the current address.
  - On write completion, address increments by 1 and remaining decrements by 1.
  - Next state is DATA_LO while remaining > 0, else CHK or FINISH.
- Only one write is outstanding at a time.
  - rx_ready = 0 while wr_en is pending and the FSM sits in DATA_HI with a complete halfword waiting.
  - Otherwise rx_ready = 1 in all states except FINISH.
- Address never wraps, because N ≤ MEM_DEPTH guarantees the last address is MEM_DEPTH-1.
- FINISH: waits for the final write to complete, then pulses done, clears core_hold, and returns to IDLE.

## Timing
- Reset values: rx_ready=0, wr_en=0, wr_isr=0, wr_addr=0, wr_data=0, core_hold=0, done=0, err=0. State is IDLE.
  - rx_ready rises on the first clk after nrst deasserts.
- All outputs are registered.
  - wr_en rises 1 cycle after the high byte is accepted.
  - wr_en, wr_addr, wr_data, and wr_isr stay stable until the wr_ready handshake.
- With wr_ready tied to 1 and back-to-back bytes, a halfword is written every 2 cycles.
- core_hold rises 1 cycle after the TARGET byte is accepted.
  - It falls in the same cycle done pulses.
  - On err, it falls 1 cycle after the error byte.
- done is 1 cycle wide, asserted 1 cycle after the last write handshake (or after CHK acceptance, whichever is later).
- Reset mid-frame: the frame is abandoned and all outputs return to reset values. Writes already completed are not undone.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A running XOR of all data bytes is kept.
  - The CHK byte is required after the data.
  - On mismatch: err=1, no done pulse, core_hold cleared. Memory contents already written remain.
- Not defined: no CHK state. FINISH follows the last halfword directly.

## Test plan
- Main load: frame 00 02 00 13 05 B3 00 with wr_ready=1 → writes (isr=0, addr 0, 0x0513), then (addr 1, 0x00B3). done pulses once; core_hold is high for the whole frame.
- ISR load with backpressure: frame 01 01 00 73 00, wr_ready held low 5 cycles → wr_en and wr_isr=1 are held stable at addr 0, data 0x0073. rx_ready stays low while a waiting halfword exists. done follows release.
- Bad target: byte 0x07 → err=1, no writes, core_hold stays 0. A following valid 00-target frame clears err.
- Oversize: length 0x0801 → err=1, returns to IDLE, no wr_en.
- Checksum (macro on): data 12 34 with CHK 0x26 → done. With CHK 0x00 → err, no done, 1 write still performed.
- Reset mid-data: nrst low after LEN_HI → all outputs return to 0. A new frame afterwards restarts at addr 0.
